target_manager: RTL and testbench

// - Sits downstream of target_rdm_gen and consumes its RND_ADDR bus.
// - Validates each candidate address and latches a valid one as the live target.
// - On each snake-head move, compares the head address against the live target.
// - On a hit: pulses TARGET_ATE (which makes target_rdm_gen advance), increments SCORE and fetches a fresh target.
// - Feeds the VGA colour mux (TARGET_ADDR) and the score display (SCORE).

---
 rtl/snake_pkg.sv | 33 +++
 rtl/target_addr_check.sv | 27 ++
 rtl/target_manager.sv | 163 ++++++++++++++++
 tb/tb_target_manager.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake game datapath.
//   ADDR_W         pixel address width, layout {Y[6:0], X[7:0]}
//   X_MAX / Y_MAX  exclusive bounds of the visible playfield
//   TIMEOUT_MOVES  head moves an uneaten target survives (only used when
//                  target_manager is built with TARGET_TIMEOUT_EN)
//   addr_x/addr_y  field extractors for a pixel address
//   tgt_state_e    target_manager FSM states
// ---------------------------------------------------------------------------
package snake_pkg;

  localparam int ADDR_W        = 15;
  localparam int X_MAX         = 160;
  localparam int Y_MAX         = 120;
  localparam int TIMEOUT_MOVES = 64;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SAMPLE = 2'd1,
    ARMED  = 2'd2,
    EATEN  = 2'd3
  } tgt_state_e;

  function automatic logic [7:0] addr_x(input logic [ADDR_W-1:0] addr);
    return addr[7:0];
  endfunction

  function automatic logic [6:0] addr_y(input logic [ADDR_W-1:0] addr);
    return addr[14:8];
  endfunction

endpackage

// File: rtl/target_addr_check.sv
// ---------------------------------------------------------------------------
// target_addr_check
// Combinational placement test for a candidate pixel address: the address
// must lie inside the playfield and must not sit on the snake head.
// Ports:
//   addr       in   ADDR_W  candidate address
//   head_addr  in   ADDR_W  most recently captured head address
//   addr_ok    out  1       1 = candidate is usable
// ---------------------------------------------------------------------------
module target_addr_check
  import snake_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] head_addr,
  output logic              addr_ok
);

  logic x_ok;
  logic y_ok;
  logic not_head;

  assign x_ok     = addr_x(addr) < 8'(X_MAX);
  assign y_ok     = addr_y(addr) < 7'(Y_MAX);
  assign not_head = addr != head_addr;
  assign addr_ok  = x_ok && y_ok && not_head;

endmodule

// File: rtl/target_manager.sv
// ---------------------------------------------------------------------------
// target_manager
// Takes candidate addresses from target_rdm_gen, latches a valid one as the
// live target, and detects when the snake head lands on it. A hit pulses
// TARGET_ATE (advancing the generator), bumps the saturating SCORE and
// fetches a fresh target after RND_LAT cycles.
// Ports:
//   CLK           in   1        rising-edge clock
//   RESET         in   1        asynchronous, active-low reset
//   GAME_ACTIVE   in   1        0 freezes all state and masks TARGET_ATE
//   HEAD_VALID    in   1        one-cycle pulse per head move
//   HEAD_ADDR     in   ADDR_W   head address, sampled with HEAD_VALID
//   RND_ADDR      in   ADDR_W   candidate target from target_rdm_gen
//   TARGET_ADDR   out  ADDR_W   live target address
//   TARGET_VALID  out  1        TARGET_ADDR holds a live target
//   TARGET_ATE    out  1        one-cycle pulse on hit (or timeout)
//   SCORE         out  SCORE_W  targets eaten, saturating
// Build option: define TARGET_TIMEOUT_EN to relocate a target that has
// survived TIMEOUT_MOVES head moves without being eaten.
// ---------------------------------------------------------------------------
module target_manager
  import snake_pkg::*;
#(
  parameter int SCORE_W = 8,
  parameter int RND_LAT = 2
)
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               GAME_ACTIVE,
  input  logic               HEAD_VALID,
  input  logic [ADDR_W-1:0]  HEAD_ADDR,
  input  logic [ADDR_W-1:0]  RND_ADDR,
  output logic [ADDR_W-1:0]  TARGET_ADDR,
  output logic               TARGET_VALID,
  output logic               TARGET_ATE,
  output logic [SCORE_W-1:0] SCORE
);

  localparam int WAIT_W = (RND_LAT < 1) ? 1 : $clog2(RND_LAT + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LOAD = WAIT_W'(RND_LAT);
  localparam logic [WAIT_W-1:0]  WAIT_ONE  = WAIT_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_SAT = {SCORE_W{1'b1}};

  tgt_state_e         state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [ADDR_W-1:0]  target_q, target_d;
  logic               valid_q, valid_d;
  logic               ate_q, ate_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [ADDR_W-1:0]  head_q, head_d;
  logic               addr_ok;
  logic               hit;

`ifdef TARGET_TIMEOUT_EN
  localparam int MV_W = $clog2(TIMEOUT_MOVES + 1);
  localparam logic [MV_W-1:0] MV_LAST = MV_W'(TIMEOUT_MOVES - 1);
  logic [MV_W-1:0] moves_q, moves_d;
`endif

  // Candidates are screened against the last captured head, not the live
  // HEAD_ADDR, so a head move in the sampling cycle cannot race the check.
  target_addr_check u_check (
    .addr      (RND_ADDR),
    .head_addr (head_q),
    .addr_ok   (addr_ok)
  );

  assign hit = HEAD_VALID && (HEAD_ADDR == target_q);

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    target_d = target_q;
    valid_d  = valid_q;
    ate_d    = 1'b0;
    score_d  = score_q;
    head_d   = head_q;
`ifdef TARGET_TIMEOUT_EN
    moves_d  = moves_q;
`endif
    // With the game paused nothing advances and any pending pulse is dropped.
    if (GAME_ACTIVE) begin
      if (HEAD_VALID) head_d = HEAD_ADDR;
      unique case (state_q)
        WAIT: begin
          // Leave on the decrement that reaches zero; the zero test covers
          // a zero latency build.
          if (wait_q <= WAIT_ONE) state_d = SAMPLE;
          if (wait_q != '0)       wait_d  = wait_q - WAIT_ONE;
        end
        SAMPLE: begin
          if (addr_ok) begin
            target_d = RND_ADDR;
            valid_d  = 1'b1;
            state_d  = ARMED;
`ifdef TARGET_TIMEOUT_EN
            moves_d  = '0;
`endif
          end
        end
        ARMED: begin
          if (hit) begin
            state_d = EATEN;
            ate_d   = 1'b1;
            valid_d = 1'b0;
            if (score_q != SCORE_SAT) score_d = score_q + SCORE_W'(1);
          end
`ifdef TARGET_TIMEOUT_EN
          // A hit on the final allowed move is taken as a hit above.
          else if (HEAD_VALID) begin
            if (moves_q == MV_LAST) begin
              state_d = EATEN;
              ate_d   = 1'b1;
              valid_d = 1'b0;
            end else begin
              moves_d = moves_q + MV_W'(1);
            end
          end
`endif
        end
        EATEN: begin
          state_d = WAIT;
          wait_d  = WAIT_LOAD;
        end
        default: state_d = WAIT;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= WAIT;
      wait_q   <= WAIT_LOAD;
      target_q <= '0;
      valid_q  <= 1'b0;
      ate_q    <= 1'b0;
      score_q  <= '0;
      head_q   <= '0;
`ifdef TARGET_TIMEOUT_EN
      moves_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      target_q <= target_d;
      valid_q  <= valid_d;
      ate_q    <= ate_d;
      score_q  <= score_d;
      head_q   <= head_d;
`ifdef TARGET_TIMEOUT_EN
      moves_q  <= moves_d;
`endif
    end
  end

  assign TARGET_ADDR  = target_q;
  assign TARGET_VALID = valid_q;
  // Masking keeps a pulse from escaping while the game is paused.
  assign TARGET_ATE   = ate_q & GAME_ACTIVE;
  assign SCORE        = score_q;

endmodule

// File: tb/tb_target_manager.sv
// ---------------------------------------------------------------------------
// tb_target_manager
// Directed bench for target_manager with a timestamp-based reference model
// and a per-cycle output compare. Honours TARGET_TIMEOUT_EN when defined.
// ---------------------------------------------------------------------------
module tb_target_manager;
  import snake_pkg::*;

  localparam int RND_LAT   = 2;
  localparam int SCORE_W   = 8;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  logic               CLK = 1'b0;
  logic               RESET = 1'b0;
  logic               GAME_ACTIVE = 1'b1;
  logic               HEAD_VALID = 1'b0;
  logic [ADDR_W-1:0]  HEAD_ADDR = '0;
  logic [ADDR_W-1:0]  RND_ADDR = '0;
  logic [ADDR_W-1:0]  TARGET_ADDR;
  logic               TARGET_VALID;
  logic               TARGET_ATE;
  logic [SCORE_W-1:0] SCORE;

  int n_chk  = 0;
  int n_fail = 0;

  target_manager #(.SCORE_W(SCORE_W), .RND_LAT(RND_LAT)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .GAME_ACTIVE  (GAME_ACTIVE),
    .HEAD_VALID   (HEAD_VALID),
    .HEAD_ADDR    (HEAD_ADDR),
    .RND_ADDR     (RND_ADDR),
    .TARGET_ADDR  (TARGET_ADDR),
    .TARGET_VALID (TARGET_VALID),
    .TARGET_ATE   (TARGET_ATE),
    .SCORE        (SCORE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Time is counted in active (unpaused) clock edges; a target may be
  // sampled only once the edge count reaches m_sample_at.
  int                m_t;
  int                m_sample_at;
  int                m_score;
  logic              m_valid;
  logic              m_ate;
  logic [ADDR_W-1:0] m_addr;
  logic [ADDR_W-1:0] m_head;
`ifdef TARGET_TIMEOUT_EN
  int                m_moves;
`endif

  function automatic bit placeable(input int a, input int head);
    return ((a % 256) < X_MAX) && ((a / 256) < Y_MAX) && (a != head);
  endfunction

  task automatic model_reset();
    m_t         = 0;
    m_sample_at = RND_LAT + 1;
    m_score     = 0;
    m_valid     = 1'b0;
    m_ate       = 1'b0;
    m_addr      = '0;
    m_head      = '0;
`ifdef TARGET_TIMEOUT_EN
    m_moves     = 0;
`endif
  endtask

  task automatic retire();
    m_valid     = 1'b0;
    m_ate       = 1'b1;
    m_sample_at = m_t + RND_LAT + 2;
  endtask

  task automatic model_step();
    m_t++;
    m_ate = 1'b0;
    if (m_valid) begin
      if (HEAD_VALID) begin
        if (HEAD_ADDR == m_addr) begin
          m_score = (m_score == SCORE_MAX) ? SCORE_MAX : m_score + 1;
          retire();
        end
`ifdef TARGET_TIMEOUT_EN
        else begin
          m_moves++;
          if (m_moves == TIMEOUT_MOVES) retire();
        end
`endif
      end
    end else if (m_t >= m_sample_at && placeable(int'(RND_ADDR), int'(m_head))) begin
      m_valid = 1'b1;
      m_addr  = RND_ADDR;
`ifdef TARGET_TIMEOUT_EN
      m_moves = 0;
`endif
    end
    if (HEAD_VALID) m_head = HEAD_ADDR;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RESET);
      if (!RESET)           model_reset();
      else if (GAME_ACTIVE) model_step();
      else                  m_ate = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      check("cmp_addr",  32'(TARGET_ADDR),  32'(m_addr));
      check("cmp_valid", 32'(TARGET_VALID), 32'(m_valid));
      check("cmp_ate",   32'(TARGET_ATE),   32'(m_ate & GAME_ACTIVE));
      check("cmp_score", 32'(SCORE),        m_score);
    end
  end

  // ---------------- stimulus ----------------
  task automatic move(input logic [ADDR_W-1:0] a);
    @(negedge CLK);
    HEAD_VALID = 1'b1;
    HEAD_ADDR  = a;
    @(negedge CLK);
    HEAD_VALID = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (TARGET_VALID !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (TARGET_VALID !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: TARGET_VALID=%b after 20 cycles, expected 1", name, TARGET_VALID);
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] cur, oth, tmp;
    RND_ADDR = 15'h0A05;
    repeat (3) @(negedge CLK);
    check("rst_valid", 32'(TARGET_VALID), 0);
    check("rst_addr",  32'(TARGET_ADDR),  0);
    check("rst_ate",   32'(TARGET_ATE),   0);
    check("rst_score", 32'(SCORE),        0);

    RESET = 1'b1;
    repeat (RND_LAT + 2) @(negedge CLK);
    check("first_valid", 32'(TARGET_VALID), 1);
    check("first_addr",  32'(TARGET_ADDR),  'h0A05);
    check("first_score", 32'(SCORE),        0);

    move(15'h0A04);
    check("near_miss_ate",   32'(TARGET_ATE), 0);
    check("near_miss_score", 32'(SCORE),      0);

    // hit, then X out of range for a while
    RND_ADDR = 15'h00A0;
    move(15'h0A05);
    check("hit_ate",   32'(TARGET_ATE),   1);
    check("hit_score", 32'(SCORE),        1);
    check("hit_valid", 32'(TARGET_VALID), 0);
    @(negedge CLK);
    check("ate_one_cycle", 32'(TARGET_ATE), 0);
    repeat (8) @(negedge CLK);
    check("x_reject", 32'(TARGET_VALID), 0);
    RND_ADDR = 15'h0310;
    wait_valid("x_then_ok");
    check("x_then_ok_addr", 32'(TARGET_ADDR), 'h0310);

    // respawn latency
    RND_ADDR = 15'h0A06;
    move(15'h0310);
    check("hit2_score", 32'(SCORE), 2);
    repeat (RND_LAT + 1) @(negedge CLK);
    check("respawn_not_yet", 32'(TARGET_VALID), 0);
    @(negedge CLK);
    check("respawn_valid", 32'(TARGET_VALID), 1);
    check("respawn_addr",  32'(TARGET_ADDR),  'h0A06);

    // head exclusion, then Y out of range
    move(15'h0A06);
    repeat (8) @(negedge CLK);
    check("head_excl_reject", 32'(TARGET_VALID), 0);
    RND_ADDR = 15'h7800;
    repeat (6) @(negedge CLK);
    check("y_reject", 32'(TARGET_VALID), 0);
    RND_ADDR = 15'h0A05;
    wait_valid("y_then_ok");
    check("y_then_ok_addr", 32'(TARGET_ADDR), 'h0A05);
    check("score3", 32'(SCORE), 3);

    // pause during a matching move
    @(negedge CLK);
    GAME_ACTIVE = 1'b0;
    HEAD_VALID  = 1'b1;
    HEAD_ADDR   = 15'h0A05;
    @(negedge CLK);
    HEAD_VALID = 1'b0;
    check("pause_ate",   32'(TARGET_ATE),   0);
    check("pause_score", 32'(SCORE),        3);
    check("pause_valid", 32'(TARGET_VALID), 1);
    repeat (3) @(negedge CLK);
    GAME_ACTIVE = 1'b1;
    @(negedge CLK);
    check("resume_score", 32'(SCORE), 3);

`ifdef TARGET_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT_MOVES - 1; i++) move(15'h0000);
    check("to_before_valid", 32'(TARGET_VALID), 1);
    move(15'h0000);
    check("to_ate",   32'(TARGET_ATE), 1);
    check("to_score", 32'(SCORE),      3);
    wait_valid("to_relatch");
    check("to_relatch_addr", 32'(TARGET_ADDR), 'h0A05);
    RND_ADDR = 15'h0310;
    for (int i = 0; i < TIMEOUT_MOVES - 1; i++) move(15'h0000);
    move(15'h0A05);
    check("to_edge_hit_ate",   32'(TARGET_ATE), 1);
    check("to_edge_hit_score", 32'(SCORE),      4);
`else
    for (int i = 0; i < 64; i++) move(15'h0000);
    check("no_to_valid", 32'(TARGET_VALID), 1);
    check("no_to_ate",   32'(TARGET_ATE),   0);
    check("no_to_score", 32'(SCORE),        3);
    RND_ADDR = 15'h0310;
    move(15'h0A05);
    check("hit4_ate",   32'(TARGET_ATE), 1);
    check("hit4_score", 32'(SCORE),      4);
`endif
    wait_valid("pre_sat");

    // drive the score to saturation
    cur = 15'h0310;
    oth = 15'h0A05;
    for (int i = 0; i < SCORE_MAX - 4; i++) begin
      RND_ADDR = oth;
      move(cur);
      wait_valid("sat_loop");
      tmp = cur;
      cur = oth;
      oth = tmp;
    end
    check("sat_reached", 32'(SCORE), 'hFF);
    RND_ADDR = oth;
    move(cur);
    check("sat_ate",   32'(TARGET_ATE), 1);
    check("sat_score", 32'(SCORE),      'hFF);

    // asynchronous reset while waiting for the next target
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("async_rst_score", 32'(SCORE),        0);
    check("async_rst_valid", 32'(TARGET_VALID), 0);
    check("async_rst_addr",  32'(TARGET_ADDR),  0);
    check("async_rst_ate",   32'(TARGET_ATE),   0);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (RND_LAT + 2) @(negedge CLK);
    check("post_rst_valid", 32'(TARGET_VALID), 1);
    check("post_rst_addr",  32'(TARGET_ADDR),  32'(oth));

    @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
